// File: rtl/psram_ctrl_if.sv
// Request/response bus between the SoC memory adapter and psram_ctrl.
// The adapter is the master; the controller is the slave.
interface psram_ctrl_if #(
   parameter int ADDR_W = 24
);
   logic              req_valid;
   logic              req_ready;
   logic              req_write;
   logic [ADDR_W-1:0] req_addr;
   logic [31:0]       req_wdata;
   logic [3:0]        req_wstrb;
   logic              resp_valid;
   logic [31:0]       resp_rdata;
   logic              resp_err;

   modport master (
      output req_valid, req_write, req_addr, req_wdata, req_wstrb,
      input  req_ready, resp_valid, resp_rdata, resp_err
   );

   modport slave (
      input  req_valid, req_write, req_addr, req_wdata, req_wstrb,
      output req_ready, resp_valid, resp_rdata, resp_err
   );
endinterface

// File: rtl/psram_ctrl.sv
// psram_ctrl: single-word bus to quad PSRAM bridge.
// Enters QPI once after reset, then serves EBh reads and 38h writes.
module psram_ctrl #(
   parameter int ADDR_W = 24,
   parameter int CE_GAP = 2
) (
   input  logic        clock,
   input  logic        reset,
   psram_ctrl_if.slave bus,
   output logic        sck,
   output logic        ce_n,
   output logic [3:0]  dio_out,
   output logic [3:0]  dio_oe,
   input  logic [3:0]  dio_in
);
   typedef enum logic [2:0] {
      INIT_CMD, GAP, IDLE, CMD, ADDR, WAIT, RDATA, WDATA
   } state_t;

   localparam logic [7:0] OP_QPI = 8'h35;
   localparam logic [7:0] OP_RD  = 8'hEB;
   localparam logic [7:0] OP_WR  = 8'h38;

   state_t      state, state_nx;
   logic        ph;
   logic [3:0]  cnt;
   logic [7:0]  gap_cnt;
   logic        inited;
   logic        wr_q;
   logic        err_q;
   logic [23:0] addr_q;
   logic [31:0] wd_q;
   logic [3:0]  last_q;
   logic [27:0] rd_sh;
   logic        done;

   logic        st_ok;
   logic [1:0]  st_lo;
   logic [3:0]  st_last;
   logic [23:0] a_req;
   logic [7:0]  op;
   logic [4:0]  a_idx;
   logic [7:0]  w_byte;
   logic [31:0] rd_full;

   // Legal strobes are single bytes, aligned halves or the full word
   always_comb begin
      st_ok   = 1'b1;
      st_lo   = 2'd0;
      st_last = 4'd1;
      unique case (bus.req_wstrb)
         4'b0001: st_lo = 2'd0;
         4'b0010: st_lo = 2'd1;
         4'b0100: st_lo = 2'd2;
         4'b1000: st_lo = 2'd3;
         4'b0011: st_last = 4'd3;
         4'b1100: begin
            st_lo   = 2'd2;
            st_last = 4'd3;
         end
         4'b1111: st_last = 4'd7;
         default: st_ok = 1'b0;
      endcase
   end

   always_comb begin
      a_req = '0;
      a_req[ADDR_W-1:0] = bus.req_addr;
      a_req[1:0] = bus.req_write ? st_lo : 2'b00;
   end

   assign op      = wr_q ? OP_WR : OP_RD;
   assign a_idx   = 5'd20 - {cnt[2:0], 2'b00};
   assign w_byte  = wd_q[{cnt[2:1], 3'b000} +: 8];
   assign rd_full = {rd_sh, dio_in};

   always_comb begin
      state_nx      = state;
      done          = 1'b0;
      sck           = 1'b0;
      ce_n          = 1'b1;
      dio_out       = 4'h0;
      dio_oe        = 4'h0;
      bus.req_ready = 1'b0;
      unique case (state)
         INIT_CMD: begin
            ce_n    = 1'b0;
            sck     = ph;
            dio_oe  = 4'b0001;
            dio_out = {3'b000, OP_QPI[3'd7 - cnt[2:0]]};
            if (ph && cnt == 4'd7) state_nx = GAP;
         end
         GAP: begin
            if (gap_cnt == 8'(CE_GAP - 1))
               state_nx = inited ? IDLE : INIT_CMD;
         end
         IDLE: begin
            bus.req_ready = 1'b1;
            if (bus.req_valid) state_nx = CMD;
         end
         CMD: begin
            if (err_q) begin
               state_nx = GAP;
               done     = 1'b1;
            end else begin
               ce_n    = 1'b0;
               sck     = ph;
               dio_oe  = 4'hF;
               dio_out = cnt[0] ? op[3:0] : op[7:4];
               if (ph && cnt == 4'd1) state_nx = ADDR;
            end
         end
         ADDR: begin
            ce_n    = 1'b0;
            sck     = ph;
            dio_oe  = 4'hF;
            dio_out = addr_q[a_idx +: 4];
            if (ph && cnt == 4'd5) state_nx = wr_q ? WDATA : WAIT;
         end
         WAIT: begin
            ce_n = 1'b0;
            sck  = ph;
            if (ph && cnt == 4'd6) state_nx = RDATA;
         end
         RDATA: begin
            ce_n = 1'b0;
            sck  = ph;
            if (ph && cnt == 4'd7) begin
               state_nx = GAP;
               done     = 1'b1;
            end
         end
         WDATA: begin
            ce_n    = 1'b0;
            sck     = ph;
            dio_oe  = 4'hF;
            dio_out = cnt[0] ? w_byte[3:0] : w_byte[7:4];
            if (ph && cnt == last_q) begin
               state_nx = GAP;
               done     = 1'b1;
            end
         end
         default: state_nx = GAP;
      endcase
   end

   // Power-up starts in GAP so the pins sit idle until INIT begins
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state   <= GAP;
         ph      <= 1'b0;
         cnt     <= '0;
         gap_cnt <= '0;
         inited  <= 1'b0;
      end else begin
         state <= state_nx;
         if (state_nx != state) begin
            ph      <= 1'b0;
            cnt     <= '0;
            gap_cnt <= '0;
         end else begin
            ph      <= ~ph;
            gap_cnt <= gap_cnt + 8'd1;
            if (ph) cnt <= cnt + 4'd1;
         end
         if (state == INIT_CMD && state_nx == GAP) inited <= 1'b1;
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         wr_q   <= 1'b0;
         err_q  <= 1'b0;
         addr_q <= '0;
         wd_q   <= '0;
         last_q <= '0;
         rd_sh  <= '0;
      end else begin
         if (state == IDLE && bus.req_valid) begin
            wr_q   <= bus.req_write;
            err_q  <= bus.req_write && !st_ok;
            addr_q <= a_req;
            wd_q   <= bus.req_wdata >> {st_lo, 3'b000};
            last_q <= st_last;
         end
         if (state == RDATA && ph) rd_sh <= {rd_sh[23:0], dio_in};
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         bus.resp_valid <= 1'b0;
         bus.resp_rdata <= '0;
         bus.resp_err   <= 1'b0;
      end else begin
         bus.resp_valid <= done;
         if (done) begin
            bus.resp_err <= err_q;
            if (!wr_q)
               bus.resp_rdata <= {rd_full[7:0], rd_full[15:8],
                                  rd_full[23:16], rd_full[31:24]};
         end
      end
   end
endmodule

// File: tb/tb_psram_ctrl.sv
// Bench for psram_ctrl: QPI PSRAM model, response scoreboard
// and directed read/write/strobe/reset vectors.
module tb_psram_ctrl;
   logic       clock;
   logic       reset;
   logic       sck;
   logic       ce_n;
   logic [3:0] dio_out;
   logic [3:0] dio_oe;
   logic [3:0] dio_in;

   psram_ctrl_if #(.ADDR_W(24)) bus ();

   psram_ctrl #(.ADDR_W(24), .CE_GAP(2)) dut (
      .clock   (clock),
      .reset   (reset),
      .bus     (bus),
      .sck     (sck),
      .ce_n    (ce_n),
      .dio_out (dio_out),
      .dio_oe  (dio_oe),
      .dio_in  (dio_in)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   int n_checks = 0;
   int n_fail   = 0;
   int n_spur   = 0;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   // PSRAM model: samples pins mid-cycle
   logic [7:0]  mem [1024];
   bit          qpi;
   bit          active;
   int          pcnt;
   int          n_xact = 0;
   int          oe_bad = 0;
   int          j;
   int          wn_cnt;
   logic [7:0]  mcmd;
   logic [23:0] maddr;
   logic [31:0] wn;
   logic [7:0]  spi_sh;
   logic [7:0]  init_bits;
   logic [7:0]  b;
   logic [3:0]  nib;
   logic [3:0]  hi;

   initial dio_in = 4'h0;

   always @(negedge clock) begin
      if (reset) begin
         qpi       = 1'b0;
         active    = 1'b0;
         init_bits = 8'h00;
      end else if (ce_n) begin
         active = 1'b0;
      end else begin
         if (!active) begin
            active = 1'b1;
            pcnt   = 0;
            n_xact++;
            mcmd   = '0;
            maddr  = '0;
            wn     = '0;
            wn_cnt = 0;
            spi_sh = '0;
         end
         if (!sck) begin
            if (qpi && mcmd == 8'hEB && pcnt >= 15 && pcnt < 23) begin
               j      = pcnt - 15;
               b      = mem[maddr[9:0] + 10'(j / 2)];
               dio_in = (j % 2 == 1) ? b[3:0] : b[7:4];
            end
         end else begin
            nib = dio_out;
            if (!qpi) begin
               if (dio_oe != 4'b0001) oe_bad++;
               spi_sh = {spi_sh[6:0], nib[0]};
               if (pcnt == 7) begin
                  init_bits = spi_sh;
                  if (spi_sh == 8'h35) qpi = 1'b1;
               end
            end else begin
               if (dio_oe != ((pcnt >= 8 && mcmd == 8'hEB) ? 4'h0 : 4'hF))
                  oe_bad++;
               if (pcnt < 2) mcmd = {mcmd[3:0], nib};
               else if (pcnt < 8) maddr = {maddr[19:0], nib};
               else if (mcmd == 8'h38) begin
                  j  = pcnt - 8;
                  wn = {wn[27:0], nib};
                  wn_cnt++;
                  if (j % 2 == 0) hi = nib;
                  else mem[maddr[9:0] + 10'(j / 2)] = {hi, nib};
               end
            end
            pcnt++;
         end
      end
   end

   // Length of the most recent ce_n-low window, in clocks
   int run = 0;
   int last_run = 0;
   always @(negedge clock) begin
      if (reset) run = 0;
      else if (!ce_n) run++;
      else if (run != 0) begin
         last_run = run;
         run      = 0;
      end
   end

   typedef struct {
      logic [31:0] rdata;
      logic        err;
      int          lat;
      int          hs;
   } exp_t;
   exp_t sb[$];

   // Latency is counted to the edge that captures resp_valid
   always @(negedge clock) begin
      if (!reset && bus.resp_valid) begin
         if (sb.size() == 0) n_spur++;
         else begin
            exp_t e;
            e = sb.pop_front();
            chk("resp_rdata", bus.resp_rdata, e.rdata);
            chk("resp_err", 32'(bus.resp_err), 32'(e.err));
            chk("resp_latency", 32'(cyc - e.hs + 1), 32'(e.lat));
         end
      end
   end

   logic [31:0] exp_hold;

   task automatic wait_ready();
      int t = 0;
      while (!bus.req_ready && t < 400) begin
         @(negedge clock);
         t++;
      end
      chk("ready_wait", 32'(t < 400), 32'd1);
   endtask

   task automatic issue(input logic wr, input logic [23:0] a,
                        input logic [31:0] d, input logic [3:0] s,
                        input logic exp_err, input int exp_lat);
      @(negedge clock);
      bus.req_valid = 1'b1;
      bus.req_write = wr;
      bus.req_addr  = a;
      bus.req_wdata = d;
      bus.req_wstrb = s;
      wait_ready();
      @(posedge clock);
      @(negedge clock);
      bus.req_valid = 1'b0;
      bus.req_addr  = 24'hFFFFFF;
      bus.req_wdata = 32'h5A5A5A5A;
      bus.req_wstrb = 4'h0;
      bus.req_write = ~wr;
      sb.push_back('{exp_hold, exp_err, exp_lat, cyc});
   endtask

   task automatic wait_resp();
      int t = 0;
      while (sb.size() != 0 && t < 200) begin
         @(negedge clock);
         t++;
      end
      chk("resp_wait", 32'(sb.size() == 0), 32'd1);
   endtask

   task automatic rd(input logic [23:0] a, input logic [31:0] exp);
      exp_hold = exp;
      issue(1'b0, a, 32'h0, 4'h0, 1'b0, 47);
      wait_resp();
   endtask

   task automatic wr(input logic [23:0] a, input logic [31:0] d,
                     input logic [3:0] s, input int n);
      issue(1'b1, a, d, s, 1'b0, (8 + 2 * n) * 2 + 1);
      wait_resp();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int nx;
      exp_hold      = '0;
      reset         = 1'b1;
      bus.req_valid = 1'b0;
      bus.req_write = 1'b0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      bus.req_wstrb = '0;
      repeat (3) @(negedge clock);
      chk("rst_ce_n", 32'(ce_n), 32'd1);
      chk("rst_sck", 32'(sck), 32'd0);
      chk("rst_oe", 32'(dio_oe), 32'd0);
      chk("rst_dout", 32'(dio_out), 32'd0);
      chk("rst_ready", 32'(bus.req_ready), 32'd0);
      chk("rst_rvalid", 32'(bus.resp_valid), 32'd0);
      chk("rst_rdata", bus.resp_rdata, 32'd0);
      chk("rst_err", 32'(bus.resp_err), 32'd0);
      reset = 1'b0;

      wait_ready();
      chk("init_bits", 32'(init_bits), 32'h35);
      chk("init_qpi", 32'(qpi), 32'd1);
      chk("init_ce_len", 32'(last_run), 32'd16);

      wr(24'h000100, 32'hDEADBEEF, 4'b1111, 4);
      chk("w1_cmd", 32'(mcmd), 32'h38);
      chk("w1_addr", 32'(maddr), 32'h000100);
      chk("w1_ce_len", 32'(last_run), 32'd32);
      chk("w1_nibs", wn, 32'hEFBEADDE);

      rd(24'h000102, 32'hDEADBEEF);
      chk("r1_cmd", 32'(mcmd), 32'hEB);
      chk("r1_addr", 32'(maddr), 32'h000100);
      chk("r1_ce_len", 32'(last_run), 32'd46);

      wr(24'h000100, 32'h00AA0000, 4'b0100, 1);
      chk("w2_addr", 32'(maddr), 32'h000102);
      chk("w2_ncnt", 32'(wn_cnt), 32'd2);
      chk("w2_nibs", wn, 32'h000000AA);
      rd(24'h000100, 32'hDEAABEEF);

      wr(24'h000100, 32'h12340000, 4'b1100, 2);
      chk("w3_addr", 32'(maddr), 32'h000102);
      chk("w3_nibs", wn, 32'h00003412);
      rd(24'h000101, 32'h1234BEEF);

      nx = n_xact;
      issue(1'b1, 24'h000100, 32'hFFFFFFFF, 4'b0101, 1'b1, 2);
      wait_resp();
      issue(1'b1, 24'h000100, 32'hFFFFFFFF, 4'b0000, 1'b1, 2);
      wait_resp();
      chk("err_no_xact", 32'(n_xact - nx), 32'd0);
      rd(24'h000100, 32'h1234BEEF);

      wr(24'h000100, 32'h77000000, 4'b1000, 1);
      chk("w4_addr", 32'(maddr), 32'h000103);
      rd(24'h000100, 32'h7734BEEF);

      issue(1'b0, 24'h000100, 32'h0, 4'h0, 1'b0, 47);
      repeat (34) @(negedge clock);
      reset = 1'b1;
      #1;
      chk("mid_ce_n", 32'(ce_n), 32'd1);
      chk("mid_sck", 32'(sck), 32'd0);
      chk("mid_oe", 32'(dio_oe), 32'd0);
      sb.delete();
      exp_hold = '0;
      repeat (3) @(negedge clock);
      chk("mid_rdata", bus.resp_rdata, 32'd0);
      reset = 1'b0;
      wait_ready();
      chk("reinit_bits", 32'(init_bits), 32'h35);
      chk("reinit_qpi", 32'(qpi), 32'd1);
      rd(24'h000100, 32'h7734BEEF);

      repeat (5) @(negedge clock);
      chk("sb_empty", 32'(sb.size()), 32'd0);
      chk("spurious_resp", 32'(n_spur), 32'd0);
      chk("oe_pattern", 32'(oe_bad), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_checks, n_fail);
      $finish;
   end
endmodule
